uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that sits directly downstream of the `cpu` external data bus. It consumes `addr`, `cs`, `wr_rd` and `data_bus_write`, and returns `data_bus_read` for bus reads. Store words are queued in a byte FIFO and serialised as 8N1 frames on `tx` at a software-programmable baud divisor. Status and divisor registers are readable through the same bus.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, 2..16.
- `DEFAULT_DIV`, 16'd434: reset value of BAUDDIV, in clock cycles per bit.

Ports (clock and reset first):
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `addr`  in  32  byte address. Only `addr[3:2]` is decoded; the upper bits are ignored and `cs` qualifies the access.
- `cs`  in  1  block select. High means the current bus cycle targets this block.
- `wr_rd`  in  1  1 = write, 0 = read. Used only when `cs`=1.
- `data_bus_write`  in  32  write data.
- `data_bus_read`  out  32  read data. Combinational from `addr[3:2]` and current register state; 0 when `cs`=0.
- `tx`  out  1  serial output, registered. Idle level is 1.

## Operation
Register map (`addr[3:2]`):
- 0 TXDATA, write-only.
  - A write pushes `data_bus_write[7:0]` into the FIFO.
  - If the FIFO is full and no pop occurs on the same edge, the byte is dropped and `ovf` is set.
  - Reads return 0.
- 1 STATUS, read-only except bit 3. Read layout:
  - bit0 `empty`, bit1 `full`, bit2 `busy` (FSM not IDLE), bit3 `ovf` (sticky), bits[8:4] `count` (0..DEPTH), others 0.
  - Writing 1 to bit3 clears `ovf`. A clear and a new overflow on the same edge leave `ovf`=1.
- 2 BAUDDIV, read/write, bits[15:0]; upper bits read 0.
  - The value 0 is treated as 1.
  - A new value takes effect at the next bit boundary; the current bit finishes at the old period.
- 3 reserved: reads 0, writes ignored.

A write is accepted on the rising edge where `cs`=1 and `wr_rd`=1. Reads have no side effects.

FIFO:
- Circular buffer with read and write pointers and a `count`.
- Push and pop on the same edge:
  - not full: `count` unchanged, both pointers advance.
  - full: push accepted, `count` stays DEPTH, no overflow.
- Pointers wrap modulo DEPTH.

Transmit FSM (states IDLE, START, DATA, STOP):
- Bit counter `bitcnt` (0..7) and period counter `divcnt`, which reloads with effective BAUDDIV − 1 at every bit boundary.
- IDLE: `tx`=1. If `count`>0, pop the head into the shift register, go to START, and drive `tx`=0.
- START: after one bit period, go to DATA with `bitcnt`=0 and `tx`=shift[0].
- DATA: one bit period per bit, LSB first. After bit 7, go to STOP with `tx`=1.
- STOP: after one bit period:
  - if `count`>0, pop and go directly to START (back-to-back frames, no idle gap);
  - otherwise go to IDLE.

Reset, including mid-frame: on the next edge the FIFO is flushed, the FSM goes to IDLE, and all registers take their reset values.

## Timing
Reset values:
- `tx`=1, `count`=0, `ovf`=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE.
- `data_bus_read`=0 when `cs`=0. It equals the register contents when `cs`=1.

Read latency: `data_bus_read` is valid in the same cycle as `addr`/`cs`, and `cpu` samples it on the following edge. There are no wait states.

Frame timing with effective divisor D, for a write accepted on edge E0 into an empty FIFO with the FSM IDLE:
- `count`=1 after E0.
- Pop on E1: `tx` falls after E1 and `count`=0.
- Each bit holds for exactly D cycles.
- Data bit k starts at E1+(k+1)·D.
- Stop bit starts at E1+9·D.
- FSM is IDLE and `busy`=0 after E1+10·D.
- Frame length is 10·D cycles.

Back-to-back frames: the next start bit begins exactly at E1+10·D.

STATUS timing: it reflects state after the most recent edge, so a push on E0 is visible in a read during the cycle following E0.

## Test plan
- After `rst`, read addresses 0x4 and 0x8 → STATUS=0x00000001 and 0x000001B2; `tx`=1.
- Write BAUDDIV=4, then TXDATA=0x1A5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. Start bit begins 1 cycle after the write edge. STATUS reads 0x1 after 40 cycles.
- BAUDDIV=2, write 9 bytes on consecutive cycles while IDLE:
  - the first byte pops on the cycle after it is written, so bytes 2..9 fill the FIFO to `count`=8 with `full`=1 and no overflow;
  - a 10th write → `ovf`=1 and `count` stays 8;
  - all 9 queued frames are sent back-to-back with no idle cycles, 180 cycles total.
- FIFO full, with the STOP→START pop coinciding with a TXDATA write → push accepted, `count` stays 8, `ovf` stays 0. Then write STATUS with bit3=1 → `ovf`=0.
- Assert `rst` for 1 cycle mid-data-bit → `tx`=1 on the next edge, STATUS=0x1, BAUDDIV=434, and no further frame is emitted.
- BAUDDIV=0 → every bit lasts 1 cycle. Reads with `cs`=0 at every address → 0. Address 0xC reads 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers on a simple
// chip-select bus, a byte FIFO, and a bit-serialiser with a programmable divisor.
module uart_tx_mmio #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        tx
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_q, baud_d;

  state_e        state_q;
  logic [2:0]    bitcnt_q;
  logic [15:0]   divcnt_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic wr_txdata, wr_status, wr_baud;
  logic empty, full, busy, bit_done, pop, push, ovf_set;
  logic [15:0] reload;
  logic [7:0]  head;
  logic        unused_bits;

  assign wr_txdata = cs && wr_rd && (addr[3:2] == 2'd0);
  assign wr_status = cs && wr_rd && (addr[3:2] == 2'd1);
  assign wr_baud   = cs && wr_rd && (addr[3:2] == 2'd2);

  assign empty    = (count_q == 5'd0);
  assign full     = (count_q == DEPTH_C);
  assign busy     = (state_q != S_IDLE);
  assign bit_done = (divcnt_q == 16'd0);

  // The FSM takes the head byte when idle or at the end of a stop bit.
  assign pop     = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
  assign push    = wr_txdata && (!full || pop);
  assign ovf_set = wr_txdata && full && !pop;

  // A divisor of 0 behaves as 1, so the reload value is 0 in both cases.
  assign reload = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;
  assign head   = mem_q[rd_ptr_q];

  assign unused_bits = ^{addr[31:4], addr[1:0], data_bus_write[31:16]};

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    ovf_d  = (ovf_q && !(wr_status && data_bus_write[3])) || ovf_set;
    baud_d = wr_baud ? data_bus_write[15:0] : baud_q;
  end

  // NOTE: the FIFO storage has no reset; emptiness is defined by count and pointers only.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_bus_write[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= DEFAULT_DIV;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      divcnt_q <= 16'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q  <= head;
            tx_q     <= 1'b0;
            divcnt_q <= reload;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
            bitcnt_q <= 3'd0;
            divcnt_q <= reload;
            state_q  <= S_DATA;
          end else begin
            divcnt_q <= divcnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            divcnt_q <= reload;
            if (bitcnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q     <= shift_q[0];
              shift_q  <= shift_q >> 1;
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else begin
            divcnt_q <= divcnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            divcnt_q <= reload;
            if (pop) begin
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            divcnt_q <= divcnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_bus_read = 32'd0;
    if (cs) begin
      case (addr[3:2])
        2'd1:    data_bus_read = {23'd0, count_q, ovf_q, busy, full, empty};
        2'd2:    data_bus_read = {16'd0, baud_q};
        default: data_bus_read = 32'd0;
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a register-access vector table followed by
// hand-written frame, FIFO-full, reset and minimum-divisor sequences.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        tx;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_mmio #(.DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .cs             (cs),
    .wr_rd          (wr_rd),
    .data_bus_write (data_bus_write),
    .data_bus_read  (data_bus_read),
    .tx             (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        cs;
    logic        wr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a write for one edge; returns 1 time unit after the accepting edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d;
    @(posedge clk); #1;
    cs = 1'b0; wr_rd = 1'b0;
  endtask

  // Combinational read between edges; consumes no clock edge.
  task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    cs = 1'b1; wr_rd = 1'b0; addr = a;
    #1;
    check(name, data_bus_read, exp);
    cs = 1'b0;
  endtask

  // Expected line level for bit slot k of a frame (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Divisor 2: nine consecutive writes from idle, then a tenth either dropped at c=9
  // (coll=0) or landing on the first STOP->START pop at c=21 (coll=1).
  task automatic run_stream(input bit coll);
    logic [7:0] bytes [10];
    int nframes, last, t;
    logic exp_tx;
    bytes = '{8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h99, 8'h66};
    nframes = coll ? 10 : 9;
    last    = coll ? 21 : 9;
    for (int c = 0; c < 20 * nframes + 6; c++) begin
      if (c < 9 || c == last) begin
        cs = 1'b1; wr_rd = 1'b1; addr = 32'h0; data_bus_write = {24'h0, bytes[c < 9 ? c : 9]};
      end
      @(posedge clk); #1;
      cs = 1'b0; wr_rd = 1'b0;
      t = c - 1;
      exp_tx = (t >= 0 && t < 20 * nframes) ? frame_bit(bytes[t / 20], (t % 20) / 2) : 1'b1;
      check($sformatf("stream%0d_tx_c%0d", coll, c), {31'd0, tx}, {31'd0, exp_tx});
      if (c == 8) check_read("stream_full_status", 32'h4, 32'h86);
      if (!coll && c == 9) check_read("stream_ovf_status", 32'h4, 32'h8E);
      if (coll && c == 20) check_read("coll_pre_status", 32'h4, 32'h86);
      if (coll && c == 21) check_read("coll_push_status", 32'h4, 32'h86);
    end
    check_read("stream_end_status", 32'h4, coll ? 32'h1 : 32'h9);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    vecs[0]  = '{32'h4, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1};
    vecs[1]  = '{32'h8, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1B2};
    vecs[2]  = '{32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[3]  = '{32'hC, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{32'h4, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{32'h8, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{32'hC, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{32'h8, 1'b0, 1'b1, 32'h7,        1'b0, 32'h0};
    vecs[9]  = '{32'h8, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1B2};
    vecs[10] = '{32'hC, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[11] = '{32'hC, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{32'h4, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1};
    vecs[13] = '{32'h8, 1'b1, 1'b1, 32'hABCD1234, 1'b0, 32'h0};
    vecs[14] = '{32'h8, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1234};
    vecs[15] = '{32'h4, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[16] = '{32'h4, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1};
    vecs[17] = '{32'h0, 1'b0, 1'b1, 32'h55,       1'b0, 32'h0};
    vecs[18] = '{32'h4, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1};

    check("reset_tx", {31'd0, tx}, 32'h1);
    for (int i = 0; i < 19; i++) begin
      cs = vecs[i].cs; wr_rd = vecs[i].wr; addr = vecs[i].a; data_bus_write = vecs[i].wdata;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_read", i), data_bus_read, vecs[i].exp);
      @(posedge clk); #1;
      cs = 1'b0; wr_rd = 1'b0;
    end
    check("idle_tx_after_table", {31'd0, tx}, 32'h1);

    // Single frame, divisor 4, byte 0xA5.
    bus_write(32'h8, 32'h4);
    bus_write(32'h0, 32'h1A5);
    check("f1_tx_after_write", {31'd0, tx}, 32'h1);
    check_read("f1_status_queued", 32'h4, 32'h10);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("f1_tx_%0d", i), {31'd0, tx}, {31'd0, frame_bit(8'hA5, i / 4)});
      if (i == 0) check_read("f1_status_busy", 32'h4, 32'h5);
    end
    @(posedge clk); #1;
    check("f1_tx_idle", {31'd0, tx}, 32'h1);
    check_read("f1_status_done", 32'h4, 32'h1);

    // FIFO fill, overflow, back-to-back frames; then ovf clear; then full push+pop.
    bus_write(32'h8, 32'h2);
    run_stream(1'b0);
    bus_write(32'h4, 32'h8);
    check_read("ovf_cleared", 32'h4, 32'h1);
    run_stream(1'b1);

    // Reset in the middle of data bit 2 of 0x5A with another byte queued.
    bus_write(32'h8, 32'h4);
    bus_write(32'h0, 32'h5A);
    bus_write(32'h0, 32'h3C);
    repeat (13) @(posedge clk);
    #1;
    check("rst_pre_tx", {31'd0, tx}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'h1);
    check_read("rst_status", 32'h4, 32'h1);
    check_read("rst_baud", 32'h8, 32'h1B2);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_quiet_%0d", i), {31'd0, tx}, 32'h1);
    end

    // Divisor 0 behaves as 1 cycle per bit.
    bus_write(32'h8, 32'h0);
    check_read("div0_read", 32'h8, 32'h0);
    bus_write(32'h0, 32'h96);
    check("div0_tx_after_write", {31'd0, tx}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check($sformatf("div0_tx_%0d", i), {31'd0, tx}, {31'd0, frame_bit(8'h96, i)});
    end
    check_read("div0_status_done", 32'h4, 32'h1);
    check_read("reserved_read", 32'hC, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
